// File: rtl/clk_div_meas.sv
// Divided-clock monitor: recovers period and high time of div_in in clk cycles, flags lock and stall.
// Outputs and meas_valid update one cycle after the sampled rise; no backpressure (meas_valid is a pulse).
module clk_div_meas #(
  parameter int CNT_W   = 10,
  parameter int LOCK_N  = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             stalled
);

  localparam int               MW        = $clog2(LOCK_N);
  localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_N - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state, state_nxt;
  logic             div_d, rise;
  logic             have_meas, have_meas_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, hi, hi_nxt;
  logic [CNT_W-1:0] period_nxt, high_nxt;
  logic [MW-1:0]    match, match_nxt, match_inc;
  logic             mv_nxt, locked_nxt, stalled_nxt;

  assign rise      = div_in & ~div_d;
  // Saturate so a long run of identical measurements keeps locked asserted.
  assign match_inc = (match == MATCH_MAX) ? match : match + MW'(1);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hi_nxt        = hi;
    period_nxt    = period_out;
    high_nxt      = high_out;
    mv_nxt        = 1'b0;
    locked_nxt    = locked;
    stalled_nxt   = stalled;
    match_nxt     = match;
    have_meas_nxt = have_meas;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        hi_nxt  = '0;
        if (rise) begin
          state_nxt   = MEASURE;
          cnt_nxt     = ONE;
          hi_nxt      = ONE;
          stalled_nxt = 1'b0;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_nxt    = cnt;
          high_nxt      = hi;
          mv_nxt        = 1'b1;
          cnt_nxt       = ONE;
          hi_nxt        = ONE;
          stalled_nxt   = 1'b0;
          have_meas_nxt = 1'b1;
          if (have_meas && (cnt == period_out) && (hi == high_out))
            match_nxt = match_inc;
          else
            match_nxt = '0;
          locked_nxt = (match_nxt == MATCH_MAX);
        end else if (cnt == TIMEOUT_C) begin
          // No edge within the window: drop back and forget lock history.
          state_nxt     = IDLE;
          stalled_nxt   = 1'b1;
          locked_nxt    = 1'b0;
          match_nxt     = '0;
          have_meas_nxt = 1'b0;
          period_nxt    = '0;
          high_nxt      = '0;
          cnt_nxt       = '0;
          hi_nxt        = '0;
        end else begin
          cnt_nxt = cnt + ONE;
          hi_nxt  = hi + {{(CNT_W-1){1'b0}}, div_in};
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_d      <= 1'b0;
      cnt        <= '0;
      hi         <= '0;
      match      <= '0;
      have_meas  <= 1'b0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      stalled    <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_d      <= div_in;
      cnt        <= cnt_nxt;
      hi         <= hi_nxt;
      match      <= match_nxt;
      have_meas  <= have_meas_nxt;
      period_out <= period_nxt;
      high_out   <= high_nxt;
      meas_valid <= mv_nxt;
      locked     <= locked_nxt;
      stalled    <= stalled_nxt;
    end
  end

endmodule

// File: tb/tb_clk_div_meas.sv
// Directed bench for clk_div_meas with a short stall window (TIMEOUT=20).
module tb_clk_div_meas;

  localparam int CNT_W = 10;
  localparam int TO    = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             div_in = 1'b0;
  logic [CNT_W-1:0] period_out, high_out;
  logic             meas_valid, locked, stalled;

  int checks = 0;
  int errors = 0;

  clk_div_meas #(.CNT_W(CNT_W), .LOCK_N(3), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .div_in    (div_in),
    .period_out(period_out),
    .high_out  (high_out),
    .meas_valid(meas_valid),
    .locked    (locked),
    .stalled   (stalled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Drive div_in away from the edge, let one clk edge sample it, then settle.
  task automatic tick(input logic d);
    div_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int mv, input int p, input int h,
                         input int lk, input int st);
    chk({tag, "_mv"},     32'(meas_valid), 32'(mv));
    chk({tag, "_period"}, 32'(period_out), 32'(p));
    chk({tag, "_high"},   32'(high_out),   32'(h));
    chk({tag, "_locked"}, 32'(locked),     32'(lk));
    chk({tag, "_stalled"},32'(stalled),    32'(st));
  endtask

  // Rising edge of div_in, then check what the edge produced.
  task automatic rise_chk(input string tag, input int mv, input int p, input int h,
                          input int lk, input int st);
    tick(1'b1);
    chk_all(tag, mv, p, h, lk, st);
  endtask

  // Rest of a period after its rising edge; no measurement may appear here.
  task automatic tail(input int h, input int l);
    for (int i = 1; i < h; i++) begin
      tick(1'b1);
      chk("tail_mv", 32'(meas_valid), 32'd0);
    end
    for (int i = 0; i < l; i++) begin
      tick(1'b0);
      chk("tail_mv", 32'(meas_valid), 32'd0);
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick(1'b0);
    tick(1'b0);
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // div_in toggling every clk: period 2, high 1
    rise_chk("tog_first", 0, 0, 0, 0, 0); tail(1, 1);
    rise_chk("tog_m1",    1, 2, 1, 0, 0); tail(1, 1);
    rise_chk("tog_m2",    1, 2, 1, 0, 0); tail(1, 1);
    rise_chk("tog_m3",    1, 2, 1, 1, 0);

    // High 2 / low 3: period 5, high 2
    tail(1, 1);
    rise_chk("p5_prev",   1, 2, 1, 1, 0); tail(2, 3);
    rise_chk("p5_m1",     1, 5, 2, 0, 0); tail(2, 3);
    rise_chk("p5_m2",     1, 5, 2, 0, 0); tail(2, 3);
    rise_chk("p5_m3",     1, 5, 2, 1, 0); tail(2, 2);

    // Period 4/2, then switch to 6/3
    rise_chk("p4_m1",     1, 4, 2, 0, 0); tail(2, 2);
    rise_chk("p4_m2",     1, 4, 2, 0, 0); tail(2, 2);
    rise_chk("p4_m3",     1, 4, 2, 1, 0); tail(3, 3);
    rise_chk("p6_switch", 1, 6, 3, 0, 0); tail(3, 3);
    rise_chk("p6_m2",     1, 6, 3, 0, 0); tail(3, 3);
    rise_chk("p6_m3",     1, 6, 3, 1, 0);

    // Hold low after lock: stall exactly TO cycles after the last rise
    for (int k = 1; k < TO; k++) tick(1'b0);
    chk_all("pre_stall", 0, 6, 3, 1, 0);
    tick(1'b0);
    chk_all("stall", 0, 0, 0, 0, 1);
    tick(1'b0);
    tick(1'b0);
    chk_all("stall_hold", 0, 0, 0, 0, 1);
    rise_chk("stall_clear", 0, 0, 0, 0, 0); tail(3, 3);
    rise_chk("post_stall_m1", 1, 6, 3, 0, 0); tail(3, 3);
    rise_chk("post_stall_m2", 1, 6, 3, 0, 0); tail(3, 3);
    rise_chk("post_stall_m3", 1, 6, 3, 1, 0);

    // One-cycle reset mid-period while locked
    tick(1'b1);
    rst = 1'b1;
    tick(1'b1);
    chk_all("midrst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    rise_chk("midrst_first", 0, 0, 0, 0, 0); tail(3, 3);
    rise_chk("midrst_m1",    1, 6, 3, 0, 0);

    // div_in held high from reset: one rise, then stall, never a measurement
    rst = 1'b1;
    tick(1'b1);
    chk_all("hold1_rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(1'b1);
    chk_all("hold1_rise", 0, 0, 0, 0, 0);
    for (int k = 1; k < TO; k++) begin
      tick(1'b1);
      chk("hold1_mv", 32'(meas_valid), 32'd0);
    end
    chk("hold1_pre_stall", 32'(stalled), 32'd0);
    tick(1'b1);
    chk_all("hold1_stall", 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) tick(1'b1);
    chk_all("hold1_after", 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
